bus_rr: RTL and testbench
=========================

# bus_rr

Parametrised shared bus connecting NUM_M masters to 2**SEL_W slaves. It is the successor of the fixed two-master/two-slave bus. Access is granted by a registered round-robin arbiter with a per-owner hold limit. The granted master's command is decoded onto one slave select, and slave read data returns one cycle later with a valid strobe.

## Interface
- NUM_M, 4, number of masters (2..8)
- SEL_W, 2, slave-index bits; NUM_S = 2**SEL_W slaves
- ADDR_W, 8, address width; slave index = address[ADDR_W-1 -: SEL_W]
- DATA_W, 32, data width
- MAX_HOLD, 4, max consecutive grant cycles while others wait; 0 = unlimited
- clk  in  1  single clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- M_req  in  NUM_M  per-master request
- M_wr  in  NUM_M  per-master write (1) / read (0)
- M_address  in  NUM_M*ADDR_W  master i at [i*ADDR_W +: ADDR_W]
- M_dout  in  NUM_M*DATA_W  master write data, master i at [i*DATA_W +: DATA_W]
- S_dout  in  NUM_S*DATA_W  slave read data, slave j at [j*DATA_W +: DATA_W]
- M_grant  out  NUM_M  registered one-hot (or zero) grant
- M_din  out  DATA_W  read data returned to masters
- M_din_valid  out  1  M_din carries a read result this cycle
- S_sel  out  NUM_S  one-hot slave select (or zero)
- S_address  out  ADDR_W  muxed address
- S_wr  out  1  muxed write strobe
- S_din  out  DATA_W  muxed write data

## Operation
- State: grant register, last_owner index, hold counter, rd_sel register (NUM_S bits).
- Reset values:
  - M_grant=0
  - last_owner=NUM_M-1, so M0 has first priority
  - hold=0, rd_sel=0
  - Resulting outputs: M_din=0, M_din_valid=0, S_sel=0, S_address=0, S_wr=0, S_din=0
- Arbiter, evaluated every edge from the current M_req:
  - No request: M_grant←0. last_owner keeps its value.
  - Owner o holds the grant and M_req[o]=1: keep the grant unless MAX_HOLD≠0, hold==MAX_HOLD-1 and another master requests.
    - hold increments, saturating, while the grant is kept.
  - Otherwise: grant the first requester searching o+1, o+2, … with wrap modulo NUM_M, where o = owner or last_owner.
    - The forced-rotation search excludes o.
    - On any new grant: last_owner←new index, hold←0.
  - A dropped owner request releases the grant at the next edge.
  - The grant is never given to a master whose M_req was 0 at that edge.
- Command mux (combinational from M_grant):
  - active = M_grant[i] & M_req[i].
  - If active: S_address/S_wr/S_din come from master i, and S_sel[index]=1.
  - If inactive: S_address=0, S_wr=0, S_din=0, S_sel=0.
- Read return:
  - rd_sel←S_sel & {NUM_S{~S_wr}} at each edge.
  - M_din = S_dout of the slave flagged in rd_sel, else 0.
  - M_din_valid = |rd_sel.
- Writes produce no M_din_valid.

## Timing
- A request asserted at edge k-1 with the bus free is granted at edge k. The transfer is on the bus in cycle k.
- Read issued in cycle k: slave samples at edge k+1. M_din/M_din_valid are valid in cycle k+1, from registered select and combinational slave data.
- Back-to-back reads by the owner: one result per cycle, pipelined.
- Ownership change takes effect at the edge. No dead cycle is inserted between owners when the next requester is already waiting.
- A read in the owner's last cycle still returns its data in the following cycle, even if the grant has moved.
- Simultaneous requests are resolved purely by rotation from last_owner.
- Wrap: the search from NUM_M-1 continues at 0.
- Reset assertion at any point clears all state immediately; outputs go to reset values asynchronously. A pending read result is discarded.

## Test plan
- Reset: reset_n=0 with all M_req=1 -> M_grant=0, S_sel=0, M_din_valid=0. After release, first grant at next edge is M_grant=4'b0001.
- Single read: M2 reads address 8'h80 (slave 2), S_dout slave2=32'hA5A5_0001 -> M_grant=4'b0100 one edge after the request. S_sel=4'b0100 and S_wr=0 in that cycle. Next cycle M_din=32'hA5A5_0001 with M_din_valid=1.
- Round robin: all four masters request continuously, MAX_HOLD=1 -> grant sequence 0001,0010,0100,1000,0001 on consecutive cycles.
- Hold limit: M0 and M3 request continuously, MAX_HOLD=4 -> M0 granted 4 cycles, M3 4 cycles, alternating. With MAX_HOLD=0, M0 keeps the grant until it drops M_req.
- Write/idle: M1 writes 32'hDEAD_BEEF to address 8'h40 -> S_sel=4'b0010, S_wr=1, S_din=32'hDEAD_BEEF, no M_din_valid. When M1 drops M_req, the grant clears next edge and the bus outputs are all 0.
- Reset mid-read: reset_n pulled low during a granted read cycle -> M_grant, S_sel and rd_sel clear at once. No M_din_valid follows after reset release.

Source files
------------

// File: rtl/bus_rr.sv
// Shared bus: NUM_M masters onto 2**SEL_W slaves through a registered round-robin arbiter
// with a per-owner hold limit; read data comes back one cycle after the command.
module bus_rr #(
  parameter int NUM_M    = 4,
  parameter int SEL_W    = 2,
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_M-1:0]              M_req,
  input  logic [NUM_M-1:0]              M_wr,
  input  logic [NUM_M*ADDR_W-1:0]       M_address,
  input  logic [NUM_M*DATA_W-1:0]       M_dout,
  input  logic [(2**SEL_W)*DATA_W-1:0]  S_dout,
  output logic [NUM_M-1:0]              M_grant,
  output logic [DATA_W-1:0]             M_din,
  output logic                          M_din_valid,
  output logic [(2**SEL_W)-1:0]         S_sel,
  output logic [ADDR_W-1:0]             S_address,
  output logic                          S_wr,
  output logic [DATA_W-1:0]             S_din
);
  localparam int NUM_S = 2**SEL_W;
  localparam int IW    = $clog2(NUM_M);
  localparam int HW    = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  // hold counter saturates here; with MAX_HOLD=0 it only runs to all-ones and is never compared
  localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : {HW{1'b1}};

  logic [NUM_M-1:0] r_grant;
  logic [IW-1:0]    r_last;
  logic [HW-1:0]    r_hold;
  logic [NUM_S-1:0] r_rd_sel;

  logic          w_own_valid;
  logic [IW-1:0] w_own;
  logic          w_others;
  logic          w_keep;
  logic          w_excl;
  logic [IW-1:0] w_base;
  logic [IW-1:0] w_idx;
  logic [IW-1:0] w_next;
  logic          w_found;
  logic          w_active;

  always_comb begin
    w_own_valid = |r_grant;
    w_own       = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (r_grant[i]) w_own = IW'(i);
    end
    w_others = |(M_req & ~r_grant);
    w_excl   = w_own_valid && M_req[w_own];
    w_keep   = w_excl && !((MAX_HOLD != 0) && (r_hold == HOLD_LAST) && w_others);
    w_base   = w_own_valid ? w_own : r_last;
    // rotation search; a forced hand-over must not land back on the current owner
    w_found  = 1'b0;
    w_next   = '0;
    w_idx    = '0;
    for (int k = 1; k <= NUM_M; k++) begin
      w_idx = IW'((int'(w_base) + k) % NUM_M);
      if (!w_found && M_req[w_idx] && !(k == NUM_M && w_excl)) begin
        w_found = 1'b1;
        w_next  = w_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_grant  <= '0;
      r_last   <= IW'(NUM_M - 1);
      r_hold   <= '0;
      r_rd_sel <= '0;
    end else begin
      r_rd_sel <= S_sel & {NUM_S{~S_wr}};
      if (M_req == '0) begin
        r_grant <= '0;
      end else if (w_keep) begin
        if (r_hold != HOLD_LAST) r_hold <= r_hold + 1'b1;
      end else if (w_found) begin
        r_grant <= NUM_M'(1) << w_next;
        r_last  <= w_next;
        r_hold  <= '0;
      end else begin
        r_grant <= '0;
      end
    end
  end

  assign M_grant = r_grant;

  always_comb begin
    w_active  = 1'b0;
    S_sel     = '0;
    S_address = '0;
    S_wr      = 1'b0;
    S_din     = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (r_grant[i] && M_req[i]) begin
        w_active  = 1'b1;
        S_address = M_address[i*ADDR_W +: ADDR_W];
        S_wr      = M_wr[i];
        S_din     = M_dout[i*DATA_W +: DATA_W];
      end
    end
    if (w_active) S_sel[S_address[ADDR_W-1 -: SEL_W]] = 1'b1;
  end

  always_comb begin
    M_din = '0;
    for (int j = 0; j < NUM_S; j++) begin
      if (r_rd_sel[j]) M_din = M_din | S_dout[j*DATA_W +: DATA_W];
    end
    M_din_valid = |r_rd_sel;
  end

endmodule

// File: tb/tb_bus_rr.sv
// Bench for bus_rr: three instances (MAX_HOLD 4, 1, 0) on shared inputs, checked each cycle
// against an ownership/rotation model plus directed expectations.
module tb_bus_rr;
  localparam int NM = 4;
  localparam int NI = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [3:0]    M_req, M_wr;
  logic [31:0]   M_address;
  logic [127:0]  M_dout, S_dout;

  logic [3:0]  grant [NI];
  logic [31:0] din   [NI];
  logic        dv    [NI];
  logic [3:0]  ssel  [NI];
  logic [7:0]  saddr [NI];
  logic        swr   [NI];
  logic [31:0] sdin  [NI];

  int total = 0, bad = 0;
  int own [NI], last [NI], hold [NI], rds [NI];

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < NI; gi++) begin : g_dut
      bus_rr #(.NUM_M(4), .SEL_W(2), .ADDR_W(8), .DATA_W(32),
               .MAX_HOLD(gi == 0 ? 4 : (gi == 1 ? 1 : 0))) u_dut (
        .clk(clk), .reset_n(reset_n), .M_req(M_req), .M_wr(M_wr),
        .M_address(M_address), .M_dout(M_dout), .S_dout(S_dout),
        .M_grant(grant[gi]), .M_din(din[gi]), .M_din_valid(dv[gi]),
        .S_sel(ssel[gi]), .S_address(saddr[gi]), .S_wr(swr[gi]), .S_din(sdin[gi]));
    end
  endgenerate

  function automatic int mh(int g);
    return (g == 0) ? 4 : ((g == 1) ? 1 : 0);
  endfunction

  task automatic chk(string tag, int g, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, g, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int g = 0; g < NI; g++) begin
      own[g] = -1; last[g] = NM - 1; hold[g] = 0; rds[g] = -1;
    end
  endtask

  task automatic check_all();
    logic [3:0] eg, es; logic [7:0] ea; logic ew; logic [31:0] ed, emd;
    for (int g = 0; g < NI; g++) begin
      eg = 0; es = 0; ea = 0; ew = 0; ed = 0; emd = 0;
      if (own[g] >= 0) begin
        eg = 4'(1 << own[g]);
        if (M_req[own[g]]) begin
          ea = M_address[own[g]*8 +: 8];
          ew = M_wr[own[g]];
          ed = M_dout[own[g]*32 +: 32];
          es = 4'(1 << ea[7:6]);
        end
      end
      if (rds[g] >= 0) emd = S_dout[rds[g]*32 +: 32];
      chk("grant", g, 64'(grant[g]), 64'(eg));
      chk("s_sel", g, 64'(ssel[g]), 64'(es));
      chk("s_addr", g, 64'(saddr[g]), 64'(ea));
      chk("s_wr", g, 64'(swr[g]), 64'(ew));
      chk("s_din", g, 64'(sdin[g]), 64'(ed));
      chk("m_din", g, 64'(din[g]), 64'(emd));
      chk("m_din_valid", g, 64'(dv[g]), 64'(rds[g] >= 0));
    end
  endtask

  task automatic model_step();
    int nrd, o; bit others, excl, keep;
    for (int g = 0; g < NI; g++) begin
      nrd = -1;
      if (own[g] >= 0 && M_req[own[g]] && !M_wr[own[g]])
        nrd = int'(M_address[own[g]*8 + 6 +: 2]);
      if (M_req == 4'b0) begin
        own[g] = -1;
      end else begin
        excl   = (own[g] >= 0) && M_req[own[g]];
        others = ((M_req & ~((own[g] >= 0) ? 4'(1 << own[g]) : 4'b0)) != 4'b0);
        keep   = excl && !(mh(g) != 0 && hold[g] >= mh(g) - 1 && others);
        if (keep) begin
          hold[g] = hold[g] + 1;
        end else begin
          o = (own[g] >= 0) ? own[g] : last[g];
          own[g] = -1;
          for (int k = 1; k <= NM; k++) begin
            if (!(k == NM && excl) && M_req[(o + k) % NM]) begin
              own[g] = (o + k) % NM; last[g] = own[g]; hold[g] = 0;
              break;
            end
          end
        end
      end
      rds[g] = nrd;
    end
  endtask

  task automatic cycle();
    #1 check_all();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    #1 check_all();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic rand_inputs();
    if ($urandom_range(0, 3) != 0) M_req[$urandom_range(0, 3)] ^= 1'b1;
    else M_req = 4'($urandom_range(0, 15));
    M_wr      = 4'($urandom_range(0, 15));
    M_address = $urandom;
    M_dout    = {$urandom, $urandom, $urandom, $urandom};
    S_dout    = {$urandom, $urandom, $urandom, $urandom};
  endtask

  initial begin
    M_req = 4'hF; M_wr = 4'h0; M_address = '0; M_dout = '0;
    S_dout = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'h0000_0000};
    reset_n = 1'b0;
    model_reset();
    #2;
    for (int g = 0; g < NI; g++) begin
      chk("rst_grant", g, 64'(grant[g]), 64'h0);
      chk("rst_sel", g, 64'(ssel[g]), 64'h0);
      chk("rst_valid", g, 64'(dv[g]), 64'h0);
    end
    check_all();
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;

    // all four request: rotation after reset starts at M0
    for (int c = 0; c < 5; c++) begin
      cycle();
      #1;
      chk("rr_h1", 1, 64'(grant[1]), 64'(4'b0001 << (c % 4)));
      chk("rr_h4", 0, 64'(grant[0]), 64'((c < 4) ? 4'b0001 : 4'b0010));
      chk("rr_h0", 2, 64'(grant[2]), 64'h1);
    end

    do_reset();
    M_req = 4'b1001;
    for (int c = 0; c < 16; c++) begin
      cycle();
      #1;
      chk("hold_h4", 0, 64'(grant[0]), 64'((((c / 4) % 2) == 0) ? 4'b0001 : 4'b1000));
      chk("hold_h1", 1, 64'(grant[1]), 64'(((c % 2) == 0) ? 4'b0001 : 4'b1000));
      chk("hold_h0", 2, 64'(grant[2]), 64'h1);
    end
    M_req = 4'b0000;
    cycle();
    #1 chk("release_h0", 2, 64'(grant[2]), 64'h0);

    // single read by M2 from slave 2
    M_address[2*8 +: 8] = 8'h80; M_wr = 4'b0000;
    S_dout[2*32 +: 32] = 32'hA5A5_0001;
    M_req = 4'b0100;
    cycle();
    #1;
    for (int g = 0; g < NI; g++) begin
      chk("rd_grant", g, 64'(grant[g]), 64'b0100);
      chk("rd_sel", g, 64'(ssel[g]), 64'b0100);
      chk("rd_wr", g, 64'(swr[g]), 64'h0);
    end
    cycle();
    #1;
    for (int g = 0; g < NI; g++) begin
      chk("rd_data", g, 64'(din[g]), 64'hA5A5_0001);
      chk("rd_valid", g, 64'(dv[g]), 64'h1);
    end
    M_req = 4'b0000;
    cycle();

    // write by M1 to slave 1, then release
    M_address[1*8 +: 8] = 8'h40; M_wr = 4'b0010; M_dout[1*32 +: 32] = 32'hDEAD_BEEF;
    M_req = 4'b0010;
    cycle();
    #1;
    for (int g = 0; g < NI; g++) begin
      chk("wr_sel", g, 64'(ssel[g]), 64'b0010);
      chk("wr_strobe", g, 64'(swr[g]), 64'h1);
      chk("wr_data", g, 64'(sdin[g]), 64'hDEAD_BEEF);
      chk("wr_novalid", g, 64'(dv[g]), 64'h0);
    end
    M_req = 4'b0000;
    cycle();
    #1;
    for (int g = 0; g < NI; g++) begin
      chk("idle_grant", g, 64'(grant[g]), 64'h0);
      chk("idle_bus", g, {ssel[g], saddr[g], swr[g], sdin[g]}, 64'h0);
    end

    // reset during a granted read discards the pending result
    M_wr = 4'b0000; M_req = 4'b0100;
    cycle();
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    for (int g = 0; g < NI; g++) begin
      chk("mid_rst_grant", g, 64'(grant[g]), 64'h0);
      chk("mid_rst_sel", g, 64'(ssel[g]), 64'h0);
      chk("mid_rst_valid", g, 64'(dv[g]), 64'h0);
    end
    M_req = 4'b0000;
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      cycle();
      #1 for (int g = 0; g < NI; g++) chk("post_rst_valid", g, 64'(dv[g]), 64'h0);
    end

    for (int c = 0; c < 400; c++) begin
      rand_inputs();
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
